// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode/branch hand-off
// and status. The fetch unit connects as master; memory, decode and branch
// logic connect as slave.
interface pc_fetch_unit_if;
    logic [31:0] nextAddr;
    logic        instr_ack;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] nextPC;
    logic        halted;

    modport master (
        input  nextAddr, instr_ack, halt, imem_rdata, imem_ready,
        output imem_req, imem_addr, instr, instr_valid, pc, nextPC, halted
    );

    modport slave (
        output nextAddr, instr_ack, halt, imem_rdata, imem_ready,
        input  imem_req, imem_addr, instr, instr_valid, pc, nextPC, halted
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// KGP-RISC program counter and instruction fetch stage.
// Fetches one instruction at a time over the req/ready handshake, holds it
// for decode until it retires, then loads the branch unit's target as the
// next PC. Optional macro FETCH_PERF_CNT_EN adds retire and stall counters.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | one boot cycle after reset, no request
// S_FETCH | request outstanding at pc, waiting for imem_ready
// S_HOLD  | instruction held for decode, waiting for instr_ack
// S_HALT  | stopped after a retire with halt; only reset leaves
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // State, PC and instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic; inputs that do not apply to the current state are ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.instr_ack) begin
                    pc_d    = bus.nextAddr;
                    state_d = bus.halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == S_HOLD);
    assign bus.pc          = pc_q;
    assign bus.nextPC      = pc_q + PC_INC;
    assign bus.halted      = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Retire and memory-stall counters; both wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (state_q == S_HOLD && bus.instr_ack)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (state_q == S_FETCH && !bus.imem_ready)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios for boot,
// sequential fetch, redirect, wait states, halt, reset mid-fetch and wrap,
// followed by randomized traffic against a transaction-level model.
module tb_pc_fetch_unit;

    logic clk;
    logic rst;
    pc_fetch_unit_if bus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
    pc_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus),
                       .fetch_count(fetch_count), .stall_count(stall_count));
`else
    pc_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the fetch stage is doing, in transaction terms.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_booting;   // waiting out the boot cycle after reset
    bit          m_fetching;  // a fetch at m_pc is outstanding
    bit          m_have;      // an instruction is held for decode
    bit          m_halted;
    logic [31:0] m_retires;
    logic [31:0] m_stalls;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_instr    = 32'h0;
        m_booting  = 1'b1;
        m_fetching = 1'b0;
        m_have     = 1'b0;
        m_halted   = 1'b0;
        m_retires  = 32'h0;
        m_stalls   = 32'h0;
    endtask

    // What one clock edge does to the fetch stage, given the inputs now applied.
    task automatic model_edge();
        if (m_booting) begin
            m_booting  = 1'b0;
            m_fetching = 1'b1;
        end else if (m_fetching) begin
            if (bus.imem_ready) begin
                m_instr    = bus.imem_rdata;
                m_fetching = 1'b0;
                m_have     = 1'b1;
            end else begin
                m_stalls = m_stalls + 32'd1;
            end
        end else if (m_have && bus.instr_ack) begin
            m_pc      = bus.nextAddr;
            m_have    = 1'b0;
            m_retires = m_retires + 32'd1;
            if (bus.halt) m_halted = 1'b1;
            else          m_fetching = 1'b1;
        end
    endtask

    task automatic check_all();
        check("imem_req", {31'h0, bus.imem_req}, {31'h0, m_fetching});
        if (m_fetching) check("imem_addr", bus.imem_addr, m_pc);
        check("instr", bus.instr, m_instr);
        check("instr_valid", {31'h0, bus.instr_valid}, {31'h0, m_have});
        check("pc", bus.pc, m_pc);
        check("nextPC", bus.nextPC, m_pc + 32'd4);
        check("halted", {31'h0, bus.halted}, {31'h0, m_halted});
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, m_retires);
        check("stall_count", stall_count, m_stalls);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit ack, input bit hlt, input logic [31:0] na,
                         input bit rdy, input logic [31:0] rd);
        bus.instr_ack  = ack;
        bus.halt       = hlt;
        bus.nextAddr   = na;
        bus.imem_ready = rdy;
        bus.imem_rdata = rd;
    endtask

    // Asynchronous reset: outputs must change before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b0;
    endtask

    task automatic seq_cycle();
        drive(1'b1, 1'b0, m_pc + 32'd4, 1'b1, m_pc ^ 32'hA5A5_0000);
        step();
    endtask

    task automatic reach_hold(input logic [31:0] addr);
        int n = 0;
        while (!(m_have && m_pc == addr) && n < 64) begin
            seq_cycle();
            n++;
        end
        if (n >= 64) check("reach_hold_timeout", m_pc, addr);
    endtask

    initial begin
        logic [31:0] s0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        do_reset();
        check("boot_nextPC", bus.nextPC, 32'h4);

        // Boot: one idle cycle, then request at 0.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        check("boot_req", {31'h0, bus.imem_req}, 32'h1);
        check("boot_addr", bus.imem_addr, 32'h0);

        // Sequential zero-wait fetch with ack held high throughout.
        for (int i = 0; i < 8; i++) seq_cycle();
        check("seq_pc_after_4", bus.pc, 32'h10);

        // Branch redirect from pc=8.
        do_reset();
        reach_hold(32'h8);
        drive(1'b0, 1'b0, 32'h40, 1'b1, 32'h1234_5678);
        step();
        step();
        check("redir_hold_pc", bus.pc, 32'h8);
        drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h0);
        step();
        check("redir_addr", bus.imem_addr, 32'h40);
        check("redir_nextPC", bus.nextPC, 32'h44);

        // Wait states at pc=4.
        do_reset();
        reach_hold(32'h4);
        check("ws_pc", bus.pc, 32'h4);
        // the hold at 4 came from a fetch: redo so we stall on the fetch of 4
        do_reset();
        reach_hold(32'h0);
        seq_cycle();
        s0 = m_stalls;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h99, 1'b0, 32'hBAD0_BAD0);
            step();
            check("ws_req", {31'h0, bus.imem_req}, 32'h1);
            check("ws_addr", bus.imem_addr, 32'h4);
        end
        check("ws_stall_delta", m_stalls - s0, 32'd3);
`ifdef FETCH_PERF_CNT_EN
        check("ws_stall_cnt", stall_count - s0, 32'd3);
`endif
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0004);
        step();
        check("ws_instr", bus.instr, 32'hCAFE_0004);

        // Halt at pc=0x10.
        do_reset();
        reach_hold(32'h10);
        drive(1'b1, 1'b1, 32'h14, 1'b1, 32'h0);
        step();
        check("halt_halted", {31'h0, bus.halted}, 32'h1);
        check("halt_pc", bus.pc, 32'h14);
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
            step();
        end
        do_reset();
        check("halt_rst_pc", bus.pc, 32'h0);

        // Reset mid-fetch with a stale ready during boot.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        do_reset();
        step();
        check("stale_instr", bus.instr, 32'h0);

        // Address wrap.
        reach_hold(32'h0);
        drive(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0);
        step();
        check("wrap_nextPC", bus.nextPC, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_0000);
        step();
        drive(1'b1, 1'b0, bus.nextPC, 1'b1, 32'h0);
        step();
        check("wrap_pc", bus.pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2 || (m_halted && $urandom_range(0, 9) == 0)) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) == 0,
                      ($urandom_range(0, 1) == 1) ? m_pc + 32'd4 : $urandom,
                      $urandom_range(0, 9) < 6,
                      $urandom);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage of KGP-RISC, directly upstream of the branch unit.
- Holds the PC and fetches from instruction memory over a req/ready handshake.
- Presents the fetched instruction to decode and supplies nextPC (PC + PC_INC) to the branch unit.
- Loads the branch unit's nextAddr as the new PC when the current instruction retires (instr_ack).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_INC, 4, increment applied to form nextPC (byte addressing).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
nextAddr  input  32  next PC from branch unit; sampled on retire.
instr_ack  input  1  decode/execute retires the held instruction this cycle.
halt  input  1  level; stop fetching after the instruction retiring this cycle.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address (= pc).
imem_rdata  input  32  instruction word from memory; valid when imem_ready=1.
imem_ready  input  1  memory completes the request this cycle.
instr  output  32  held instruction word.
instr_valid  output  1  instr holds a fetched, not yet retired instruction.
pc  output  32  address of the held/being-fetched instruction.
nextPC  output  32  pc + PC_INC, combinational, to branch unit.
halted  output  1  unit is in S_HALT.

Behaviour:
- Reset (async, immediate): state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, nextPC=RESET_PC+PC_INC.
- States and outputs (Moore):
  - S_IDLE: imem_req=0.
  - S_FETCH: imem_req=1, imem_addr=pc.
  - S_HOLD: instr_valid=1.
  - S_HALT: halted=1, imem_req=0.
- S_IDLE -> S_FETCH unconditionally on the first edge after rst deasserts (one boot cycle).
- S_FETCH, imem_ready=1: instr<=imem_rdata, instr_valid<=1, -> S_HOLD.
- S_FETCH, imem_ready=0: stay; imem_req and imem_addr held stable.
- S_HOLD, instr_ack=1: pc<=nextAddr (full 32 bits, no alignment masking), instr_valid<=0.
  - halt=1: -> S_HALT.
  - halt=0: -> S_FETCH.
- S_HOLD, instr_ack=0: stay; instr and pc stable.
- S_HALT: sticky; only rst exits.
- Latency: zero-wait memory gives 1 fetch cycle + >=1 hold cycle, so at most one instruction per 2 cycles. The instruction is visible the cycle after imem_ready.
- Ignored inputs:
  - instr_ack outside S_HOLD is ignored. This includes a cycle where imem_ready=1 in S_FETCH.
  - halt outside S_HOLD-with-ack is ignored. An in-flight fetch is never aborted by halt.
  - imem_ready outside S_FETCH is ignored. imem_rdata is sampled only with imem_ready in S_FETCH.
- Arithmetic: nextPC = pc + PC_INC, modulo 2^32. 32'hFFFF_FFFC + 4 = 0.
- Reset mid-fetch: imem_req drops asynchronously, the transaction is abandoned, and any later imem_ready is ignored until S_FETCH is re-entered.
- Memory contract: memory must not assert imem_ready without imem_req.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on every retire (S_HOLD and instr_ack).
  - stall_count increments each S_FETCH cycle with imem_ready=0.
  - Both wrap modulo 2^32; neither counts in S_HALT.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset/boot:
   - rst=1 -> pc=0, instr_valid=0, imem_req=0, nextPC=4.
   - Release rst -> 1 cycle later imem_req=1, imem_addr=0.
2. Sequential, zero-wait:
   - Stimulus: imem_ready=1 always; ack every instr_valid cycle; nextAddr=nextPC; imem_rdata=addr^32'hA5A5_0000.
   - Response: fetch addresses 0,4,8,12; instr matches per address; instr_valid alternates 0/1.
3. Branch redirect:
   - At pc=8, ack with nextAddr=32'h40 -> next imem_addr=32'h40, nextPC=32'h44.
   - Ack-less hold cycles keep pc=8.
4. Wait states:
   - imem_ready low 3 cycles at pc=4 -> imem_req=1 and imem_addr=4 held 4 cycles; instr_valid=0.
   - With FETCH_PERF_CNT_EN, stall_count+=3.
5. Halt:
   - halt=1 with ack at pc=32'h10, nextAddr=32'h14 -> halted=1, imem_req=0, pc=32'h14.
   - Further ack/ready ignored for 10 cycles; rst returns pc=0, halted=0.
6. Reset mid-fetch / wrap:
   - rst pulse while imem_req=1 -> imem_req=0 before next edge; a stale imem_ready during S_IDLE does not load instr.
   - nextAddr=32'hFFFF_FFFC -> nextPC=0.
